alut_lkp_engine18: RTL and testbench

ALUT_LKP_ENGINE18 -- requirements
Module: alut_lkp_engine18

---
 rtl/alut_lkp_engine18_if.sv | 44 ++++
 rtl/alut_lkp_engine18.sv | 217 +++++++++++++++++++++
 tb/tb_alut_lkp_engine18.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alut_lkp_engine18_if.sv
// Request/response bundle for the address lookup engine.
// Handshake: a request transfers on the rising clock edge where lkp_valid18
// and lkp_ready18 are both high; the requester holds its request fields
// stable while lkp_valid18 is high. res_valid18 is a one-cycle strobe that
// qualifies d_port18, and no backpressure is applied to it.
interface alut_lkp_engine18_if #(
   parameter int PW = 2,
   parameter int TW = 32
);
   localparam int NPORT = 2**PW;

   logic             lkp_valid18;
   logic             lkp_ready18;
   logic [47:0]      d_addr18;
   logic [47:0]      s_addr18;
   logic [47:0]      mac_addr18;
   logic [PW-1:0]    s_port18;
   logic [TW-1:0]    curr_time18;
   logic [TW-1:0]    best_bfr_age18;
   logic             flush18;
   logic             clear_reused18;
   logic             res_valid18;
   logic [NPORT:0]   d_port18;
   logic             reused18;
   logic             busy18;
   logic [15:0]      hit_cnt18;
   logic [15:0]      miss_cnt18;

   // Requester side
   modport master (
      output lkp_valid18, d_addr18, s_addr18, mac_addr18, s_port18,
             curr_time18, best_bfr_age18, flush18, clear_reused18,
      input  lkp_ready18, res_valid18, d_port18, reused18, busy18,
             hit_cnt18, miss_cnt18
   );

   // Engine side
   modport slave (
      input  lkp_valid18, d_addr18, s_addr18, mac_addr18, s_port18,
             curr_time18, best_bfr_age18, flush18, clear_reused18,
      output lkp_ready18, res_valid18, d_port18, reused18, busy18,
             hit_cnt18, miss_cnt18
   );
endinterface

// File: rtl/alut_lkp_engine18.sv
// Address learning / lookup engine for an NPORT-port Ethernet switch.
// A direct-mapped table indexed by an XOR-folded MAC hash learns source
// addresses and resolves destination addresses to a port mask, with entry
// ageing, whole-table flush and a sticky "entry reused" flag.
// Optional feature macro: ALUT18_HIT_CNT_EN enables 16-bit saturating
// hit/miss counters; without it hit_cnt18/miss_cnt18 are tied to zero.
module alut_lkp_engine18 #(
   parameter int PW = 2,
   parameter int AW = 8,
   parameter int TW = 32
) (
   input  logic                   pclk18,
   input  logic                   n_p_reset18,
   alut_lkp_engine18_if.slave     bus,
   output logic [2:0]             state_dbg18
);
   localparam int NPORT = 2**PW;
   localparam int DEPTH = 2**AW;
   localparam int NCH   = (48 + AW - 1) / AW;
   localparam int PADW  = NCH * AW;
   localparam logic [NPORT:0] DP_ONE = (NPORT+1)'(1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LEARN  = 3'd1,
      S_LOOKUP = 3'd2,
      S_RESP   = 3'd3,
      S_FLUSH  = 3'd4
   } state_t;

   state_t            state;

   // Table storage
   logic [DEPTH-1:0]  tbl_valid;
   logic [47:0]       tbl_addr [DEPTH];
   logic [PW-1:0]     tbl_port [DEPTH];
   logic [TW-1:0]     tbl_time [DEPTH];

   // Request captured at the handshake
   logic [47:0]       d_q, s_q, mac_q;
   logic [PW-1:0]     sp_q;
   logic [TW-1:0]     t_q, age_q;

   logic              flush_pend;
   logic [AW-1:0]     fl_idx;
   logic              aged_q;
   logic [AW-1:0]     aged_idx;
   logic              ready_q, res_valid_q, reused_q, busy_q;
   logic [NPORT:0]    d_port_q;

   // XOR of the zero-padded address split into AW-bit chunks
   function automatic logic [AW-1:0] hash_fn(input logic [47:0] a);
      logic [PADW-1:0] p;
      logic [AW-1:0]   h;
      p = PADW'(a);
      h = '0;
      for (int i = 0; i < NCH; i++) h = h ^ p[i*AW +: AW];
      return h;
   endfunction

   logic [AW-1:0]     s_idx, d_idx;
   logic              learn_en, learn_reuse;
   logic [NPORT-1:0]  flood_mask;
   logic              d_special, d_hit, d_fresh;
   logic [TW-1:0]     d_age;

   assign s_idx       = hash_fn(s_q);
   assign d_idx       = hash_fn(d_q);
   assign learn_en    = ~s_q[40];
   assign learn_reuse = tbl_valid[s_idx] && (tbl_addr[s_idx] != s_q);
   assign flood_mask  = ~(NPORT'(1) << sp_q);
   assign d_special   = (d_q == mac_q) || (&d_q);
   assign d_hit       = tbl_valid[d_idx] && (tbl_addr[d_idx] == d_q);
   assign d_age       = t_q - tbl_time[d_idx];
   assign d_fresh     = d_age <= age_q;

   logic [NPORT:0]    lk_port;
   logic              lk_aged;

   // Destination resolution in priority order: self, broadcast, fresh hit, flood
   always_comb begin
      lk_port = '0;
      lk_aged = 1'b0;
      if (d_q == mac_q) begin
         lk_port = DP_ONE << NPORT;
      end else if (&d_q) begin
         lk_port = {1'b0, flood_mask};
      end else if (d_hit && d_fresh) begin
         if (tbl_port[d_idx] != sp_q) lk_port = DP_ONE << tbl_port[d_idx];
      end else begin
         lk_aged = d_hit;
         lk_port = {1'b0, flood_mask};
      end
   end

`ifdef ALUT18_HIT_CNT_EN
   logic [15:0] hit_cnt_q, miss_cnt_q;
   logic        cnt_hit, cnt_miss;
   assign cnt_hit  = ~d_special & d_hit & d_fresh;
   assign cnt_miss = ~d_special & ~(d_hit & d_fresh);
`endif

   // Control FSM, table updates and registered outputs
   always_ff @(posedge pclk18 or negedge n_p_reset18) begin
      if (!n_p_reset18) begin
         state       <= S_IDLE;
         tbl_valid   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            tbl_addr[i] <= '0;
            tbl_port[i] <= '0;
            tbl_time[i] <= '0;
         end
         d_q         <= '0;
         s_q         <= '0;
         mac_q       <= '0;
         sp_q        <= '0;
         t_q         <= '0;
         age_q       <= '0;
         flush_pend  <= 1'b0;
         fl_idx      <= '0;
         aged_q      <= 1'b0;
         aged_idx    <= '0;
         ready_q     <= 1'b1;
         res_valid_q <= 1'b0;
         reused_q    <= 1'b0;
         busy_q      <= 1'b0;
         d_port_q    <= '0;
`ifdef ALUT18_HIT_CNT_EN
         hit_cnt_q   <= '0;
         miss_cnt_q  <= '0;
`endif
      end else begin
         res_valid_q <= 1'b0;
         if (bus.flush18)        flush_pend <= 1'b1;
         // An overwrite in LEARN below wins over a simultaneous clear
         if (bus.clear_reused18) reused_q   <= 1'b0;
         case (state)
            S_IDLE: begin
               if (flush_pend) begin
                  state      <= S_FLUSH;
                  busy_q     <= 1'b1;
                  fl_idx     <= '0;
                  flush_pend <= bus.flush18;
                  ready_q    <= 1'b0;
`ifdef ALUT18_HIT_CNT_EN
                  hit_cnt_q  <= '0;
                  miss_cnt_q <= '0;
`endif
               end else if (bus.lkp_valid18 && ready_q) begin
                  d_q     <= bus.d_addr18;
                  s_q     <= bus.s_addr18;
                  mac_q   <= bus.mac_addr18;
                  sp_q    <= bus.s_port18;
                  t_q     <= bus.curr_time18;
                  age_q   <= bus.best_bfr_age18;
                  ready_q <= 1'b0;
                  state   <= S_LEARN;
               end else if (bus.flush18) begin
                  // Pending flush must not be overtaken by a new request
                  ready_q <= 1'b0;
               end
            end
            S_LEARN: begin
               if (learn_en) begin
                  if (learn_reuse) reused_q <= 1'b1;
                  tbl_valid[s_idx] <= 1'b1;
                  tbl_addr[s_idx]  <= s_q;
                  tbl_port[s_idx]  <= sp_q;
                  tbl_time[s_idx]  <= t_q;
               end
               state <= S_LOOKUP;
            end
            S_LOOKUP: begin
               d_port_q    <= lk_port;
               res_valid_q <= 1'b1;
               aged_q      <= lk_aged;
               aged_idx    <= d_idx;
`ifdef ALUT18_HIT_CNT_EN
               if (cnt_hit && hit_cnt_q != 16'hFFFF)   hit_cnt_q  <= hit_cnt_q + 16'd1;
               if (cnt_miss && miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
`endif
               state <= S_RESP;
            end
            S_RESP: begin
               if (aged_q) tbl_valid[aged_idx] <= 1'b0;
               ready_q <= ~(flush_pend | bus.flush18);
               state   <= S_IDLE;
            end
            S_FLUSH: begin
               tbl_valid[fl_idx] <= 1'b0;
               fl_idx <= fl_idx + AW'(1);
               if (fl_idx == AW'(DEPTH-1)) begin
                  busy_q  <= 1'b0;
                  ready_q <= ~(flush_pend | bus.flush18);
                  state   <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.lkp_ready18 = ready_q;
   assign bus.res_valid18 = res_valid_q;
   assign bus.d_port18    = d_port_q;
   assign bus.reused18    = reused_q;
   assign bus.busy18      = busy_q;
   assign state_dbg18     = state;

`ifdef ALUT18_HIT_CNT_EN
   assign bus.hit_cnt18   = hit_cnt_q;
   assign bus.miss_cnt18  = miss_cnt_q;
`else
   assign bus.hit_cnt18   = '0;
   assign bus.miss_cnt18  = '0;
`endif
endmodule

// File: tb/tb_alut_lkp_engine18.sv
// Bench for alut_lkp_engine18: directed scenarios plus randomized traffic,
// scored against a behavioural table model.
module tb_alut_lkp_engine18;
   localparam int PW    = 2;
   localparam int AW    = 8;
   localparam int TW    = 32;
   localparam int NPORT = 2**PW;
   localparam int DEPTH = 2**AW;

   // ---------------- clock / reset ----------------
   logic pclk18 = 1'b0;
   logic n_p_reset18 = 1'b0;
   logic [2:0] state_dbg18;
   always #5 pclk18 = ~pclk18;

   int unsigned cyc = 0;
   always @(posedge pclk18) cyc <= cyc + 1;

   alut_lkp_engine18_if #(.PW(PW), .TW(TW)) bus ();

   alut_lkp_engine18 #(.PW(PW), .AW(AW), .TW(TW)) dut (
      .pclk18      (pclk18),
      .n_p_reset18 (n_p_reset18),
      .bus         (bus),
      .state_dbg18 (state_dbg18)
   );

   // ---------------- scoreboard state ----------------
   int checks = 0;
   int passes = 0;
   logic [NPORT:0] exp_q[$];
   int unsigned    exp_cyc_q[$];
   bit             exp_reused_q[$];
   logic [NPORT:0] last_dport = '0;

   // ---------------- behavioural model ----------------
   bit             m_valid [DEPTH];
   logic [47:0]    m_addr  [DEPTH];
   logic [PW-1:0]  m_port  [DEPTH];
   logic [TW-1:0]  m_time  [DEPTH];
   bit             m_reused = 0;
   int             m_hit = 0;
   int             m_miss = 0;

   localparam logic [47:0] MAC  = 48'h0002_0304_0506;
   localparam logic [47:0] BC   = 48'hFFFF_FFFF_FFFF;
   localparam logic [47:0] S_MC = 48'h0100_0000_0000;

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act === req) passes++;
      else $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
   endfunction

   function automatic int unsigned mhash(input logic [47:0] a);
      int unsigned h = 0;
      logic [47:0] x = a;
      while (x != 0) begin
         h = h ^ int'(x & 48'(DEPTH-1));
         x = x >> AW;
      end
      return h;
   endfunction

   function automatic void model_clear_table();
      for (int i = 0; i < DEPTH; i++) m_valid[i] = 0;
   endfunction

   function automatic logic [NPORT:0] model_req(input logic [47:0] d, input logic [47:0] s,
         input logic [PW-1:0] sp, input logic [TW-1:0] t, input logic [TW-1:0] age, input bit clr);
      int unsigned h;
      logic [NPORT:0] flood, r;
      logic [TW-1:0] diff;
      flood = '0;
      for (int p = 0; p < NPORT; p++) if (p != int'(sp)) flood[p] = 1'b1;
      if (clr) m_reused = 0;
      if (!s[40]) begin
         h = mhash(s);
         if (m_valid[h] && m_addr[h] != s) m_reused = 1;
         m_valid[h] = 1; m_addr[h] = s; m_port[h] = sp; m_time[h] = t;
      end
      r = '0;
      if (d == MAC) r[NPORT] = 1'b1;
      else if (d == BC) r = flood;
      else begin
         h = mhash(d);
         diff = t - m_time[h];
         if (m_valid[h] && m_addr[h] == d && diff <= age) begin
            if (m_hit < 65535) m_hit++;
            if (m_port[h] != sp) r[m_port[h]] = 1'b1;
         end else begin
            if (m_valid[h] && m_addr[h] == d) m_valid[h] = 0;
            if (m_miss < 65535) m_miss++;
            r = flood;
         end
      end
      return r;
   endfunction

   // ---------------- compare process ----------------
   always @(negedge pclk18) begin
      if (n_p_reset18) begin
         if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) begin
            check("res_valid_strobe", 64'(bus.res_valid18), 64'(1));
            check("d_port", 64'(bus.d_port18), 64'(exp_q[0]));
            check("reused_at_strobe", 64'(bus.reused18), 64'(exp_reused_q[0]));
            last_dport = bus.d_port18;
            void'(exp_q.pop_front());
            void'(exp_cyc_q.pop_front());
            void'(exp_reused_q.pop_front());
         end else begin
            check("res_valid_quiet", 64'(bus.res_valid18), 64'(0));
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Called at a negedge; returns at the negedge after the handshake edge
   // (one more cycle later when clr is set).
   task automatic do_req(input logic [47:0] d, input logic [47:0] s, input logic [PW-1:0] sp,
         input logic [TW-1:0] t, input logic [TW-1:0] age, input bit clr, output logic [NPORT:0] expv);
      int n = 0;
      while (!bus.lkp_ready18 && n < 1000) begin @(negedge pclk18); n++; end
      if (!bus.lkp_ready18) check("ready_timeout", 64'(bus.lkp_ready18), 64'(1));
      bus.d_addr18 = d; bus.s_addr18 = s; bus.s_port18 = sp;
      bus.curr_time18 = t; bus.best_bfr_age18 = age; bus.mac_addr18 = MAC;
      bus.lkp_valid18 = 1'b1;
      @(posedge pclk18);
      @(negedge pclk18);
      bus.lkp_valid18 = 1'b0;
      bus.d_addr18 = $urandom(); bus.s_addr18 = $urandom(); bus.s_port18 = PW'($urandom());
      expv = model_req(d, s, sp, t, age, clr);
      exp_q.push_back(expv);
      exp_cyc_q.push_back(cyc + 2);
      exp_reused_q.push_back(m_reused);
      if (clr) begin
         bus.clear_reused18 = 1'b1;
         @(negedge pclk18);
         bus.clear_reused18 = 1'b0;
      end
   endtask

   task automatic wait_done();
      int n = 0;
      while (exp_q.size() > 0 && n < 100) begin @(negedge pclk18); n++; end
      if (exp_q.size() > 0) begin
         check("strobe_timeout", 64'(exp_q.size()), 64'(0));
         exp_q.delete(); exp_cyc_q.delete(); exp_reused_q.delete();
      end
   endtask

   task automatic do_flush();
      int n = 0;
      int cnt = 0;
      bus.flush18 = 1'b1;
      @(negedge pclk18);
      bus.flush18 = 1'b0;
      while (!bus.busy18 && n < 100) begin @(negedge pclk18); n++; end
      while (bus.busy18 && cnt < 1000) begin cnt++; @(negedge pclk18); end
      check("busy_cycles", 64'(cnt), 64'(DEPTH));
      check("ready_after_flush", 64'(bus.lkp_ready18), 64'(1));
      model_clear_table();
      m_hit = 0; m_miss = 0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"},     64'(bus.lkp_ready18), 64'(1));
      check({tag, "_res_valid"}, 64'(bus.res_valid18), 64'(0));
      check({tag, "_d_port"},    64'(bus.d_port18),    64'(0));
      check({tag, "_reused"},    64'(bus.reused18),    64'(0));
      check({tag, "_busy"},      64'(bus.busy18),      64'(0));
      check({tag, "_hit_cnt"},   64'(bus.hit_cnt18),   64'(0));
      check({tag, "_miss_cnt"},  64'(bus.miss_cnt18),  64'(0));
   endtask

   // ---------------- main sequence ----------------
   localparam logic [47:0] A  = 48'h0011_2233_4455;  // hash 0x11
   localparam logic [47:0] B2 = 48'h0000_0000_0011;  // hash 0x11, collides with A
   localparam logic [47:0] C  = 48'h0000_0000_0077;
   localparam logic [47:0] E  = 48'h0000_0000_0022;
   localparam logic [47:0] G  = 48'h0000_0000_0033;
   localparam logic [47:0] M  = 48'h01AA_0000_0000;  // multicast source

   initial begin
      logic [NPORT:0] ev;
      logic [47:0] pool [12];
      logic [TW-1:0] cur_t;
      bus.lkp_valid18 = 0; bus.d_addr18 = 0; bus.s_addr18 = 0; bus.mac_addr18 = MAC;
      bus.s_port18 = 0; bus.curr_time18 = 0; bus.best_bfr_age18 = 0;
      bus.flush18 = 0; bus.clear_reused18 = 0;
      model_clear_table();

      repeat (3) @(negedge pclk18);
      check_reset_outputs("reset");
      n_p_reset18 = 1'b1;
      @(negedge pclk18);

      // Learn A on port 1, then look it up from port 2
      do_req(MAC, A, 2'd1, 32'd10, 32'd1000, 0, ev); wait_done();
      check("model_mac_a", 64'(ev), 64'(5'b1_0000));
      do_req(A, C, 2'd2, 32'd20, 32'd1000, 0, ev); wait_done();
      check("model_hit_a", 64'(ev), 64'(5'b0_0010));
      check("dut_hit_a", 64'(last_dport), 64'(5'b0_0010));

      // Switch address and broadcast
      do_req(MAC, C, 2'd2, 32'd21, 32'd1000, 0, ev); wait_done();
      check("dut_self", 64'(last_dport), 64'(5'b1_0000));
      do_req(BC, S_MC, 2'd0, 32'd22, 32'd1000, 0, ev); wait_done();
      check("model_bcast", 64'(ev), 64'(5'b0_1110));
      check("dut_bcast", 64'(last_dport), 64'(5'b0_1110));

      // Same-port hit is filtered
      do_req(A, S_MC, 2'd1, 32'd23, 32'd1000, 0, ev); wait_done();
      check("dut_filter", 64'(last_dport), 64'(5'b0_0000));

      // Multicast source is never learned
      do_req(MAC, M, 2'd2, 32'd24, 32'd1000, 0, ev); wait_done();
      do_req(M, S_MC, 2'd0, 32'd25, 32'd1000, 0, ev); wait_done();
      check("dut_mc_not_learned", 64'(last_dport), 64'(5'b0_1110));

      // Ageing: 51 > 50 floods and invalidates, 50 still hits
      do_req(MAC, E, 2'd3, 32'd100, 32'd50, 0, ev); wait_done();
      do_req(E, S_MC, 2'd1, 32'd151, 32'd50, 0, ev); wait_done();
      check("model_aged", 64'(ev), 64'(5'b0_1101));
      check("dut_aged", 64'(last_dport), 64'(5'b0_1101));
      do_req(E, S_MC, 2'd1, 32'd152, 32'd1000, 0, ev); wait_done();
      check("dut_aged_invalidated", 64'(last_dport), 64'(5'b0_1101));
      do_req(MAC, G, 2'd3, 32'd100, 32'd50, 0, ev); wait_done();
      do_req(G, S_MC, 2'd1, 32'd150, 32'd50, 0, ev); wait_done();
      check("dut_age_boundary", 64'(last_dport), 64'(5'b0_1000));

      // Reused flag: set, cleared, then clear racing an overwrite
      check("reused_before", 64'(bus.reused18), 64'(0));
      do_req(MAC, B2, 2'd0, 32'd200, 32'd1000, 0, ev); wait_done();
      check("reused_set", 64'(bus.reused18), 64'(1));
      bus.clear_reused18 = 1'b1; @(negedge pclk18); bus.clear_reused18 = 1'b0;
      m_reused = 0;
      check("reused_cleared", 64'(bus.reused18), 64'(0));
      do_req(MAC, A, 2'd1, 32'd201, 32'd1000, 1, ev); wait_done();
      check("reused_clear_race", 64'(bus.reused18), 64'(1));

      // Flush during a request: result first, then flush, then A floods
      do_req(A, S_MC, 2'd2, 32'd210, 32'd1000, 0, ev);
      check("model_prior_hit", 64'(ev), 64'(5'b0_0010));
      do_flush();
      wait_done();
      check("dut_prior_hit", 64'(last_dport), 64'(5'b0_0010));
      do_req(A, S_MC, 2'd2, 32'd211, 32'd1000, 0, ev); wait_done();
      check("dut_after_flush", 64'(last_dport), 64'(5'b0_1011));

      // Reset while the request sits in LOOKUP
      do_req(MAC, A, 2'd1, 32'd300, 32'd1000, 0, ev); wait_done();
      do_req(A, C, 2'd3, 32'd301, 32'd1000, 0, ev);
      @(negedge pclk18);
      n_p_reset18 = 1'b0;
      exp_q.delete(); exp_cyc_q.delete(); exp_reused_q.delete();
      model_clear_table(); m_reused = 0; m_hit = 0; m_miss = 0;
      repeat (3) @(negedge pclk18);
      check_reset_outputs("midreq");
      n_p_reset18 = 1'b1;
      @(negedge pclk18);
      check("no_strobe_after_reset", 64'(bus.res_valid18), 64'(0));
      do_req(A, S_MC, 2'd0, 32'd310, 32'd1000, 0, ev); wait_done();
      check("dut_table_empty", 64'(last_dport), 64'(5'b0_1110));

      // Randomized traffic with colliding pairs and timestamp wrap
      for (int i = 0; i < 6; i++) begin
         pool[i] = {$urandom(), $urandom()} & 48'hFEFF_FFFF_FFFF;
         pool[i+6] = pool[i] ^ 48'h0000_0000_0101;
      end
      cur_t = 32'hFFFF_FF00;
      for (int k = 0; k < 300; k++) begin
         logic [47:0] d, s;
         int r;
         r = $urandom_range(0, 9);
         if (r == 0) d = MAC;
         else if (r == 1) d = BC;
         else d = pool[$urandom_range(0, 11)];
         r = $urandom_range(0, 9);
         if (r < 2) s = pool[$urandom_range(0, 11)] | S_MC;
         else s = pool[$urandom_range(0, 11)];
         cur_t = cur_t + TW'($urandom_range(0, 20));
         do_req(d, s, PW'($urandom_range(0, NPORT-1)), cur_t, TW'($urandom_range(0, 60)), 0, ev);
         if ($urandom_range(0, 59) == 0) begin
            wait_done();
            do_flush();
         end
      end
      wait_done();

`ifdef ALUT18_HIT_CNT_EN
      check("hit_cnt_end",  64'(bus.hit_cnt18),  64'(m_hit));
      check("miss_cnt_end", 64'(bus.miss_cnt18), 64'(m_miss));
`else
      check("hit_cnt_end",  64'(bus.hit_cnt18),  64'(0));
      check("miss_cnt_end", 64'(bus.miss_cnt18), 64'(0));
`endif

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
